// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM host-port arbiter.
// Holds the default bus widths and the arbiter FSM encoding.
package sdram_pkg;

  localparam int SDARB_ADDR_W = 24;
  localparam int SDARB_DATA_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-requester round-robin pick.
// Returns the index of the winner; a tie goes to the port not in last_i.
module sdram_rr_pick (
  input  logic [1:0] eligible_i,
  input  logic       last_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = 1'b0;
    case (eligible_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller host port.
// Define SDARB_STATS_EN to add saturating per-port completion counters.
module sdram_host_arbiter
  import sdram_pkg::*;
#(
`ifdef SDARB_STATS_EN
  parameter int CNT_W  = 16,
`endif
  parameter int ADDR_W = SDARB_ADDR_W,
  parameter int DATA_W = SDARB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              p0_rd_i,
  input  logic              p0_wr_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_done_o,
  input  logic              p1_rd_i,
  input  logic              p1_wr_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_done_o,
  output logic              ctrl_rd_o,
  output logic              ctrl_wr_o,
  output logic [ADDR_W-1:0] ctrl_addr_o,
  output logic [DATA_W-1:0] ctrl_data_o,
  input  logic [DATA_W-1:0] ctrl_data_i,
  input  logic              ctrl_done_i
`ifdef SDARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  p0_count_o,
  output logic [CNT_W-1:0]  p1_count_o
`endif
);

  arb_state_e state_q, state_d;

  logic [1:0] rd, wr, elig;
  logic [1:0] done_q, done_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic       pick;

  logic              crd_q, crd_d;
  logic              cwr_q, cwr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  assign rd = {p1_rd_i, p0_rd_i};
  assign wr = {p1_wr_i, p0_wr_i};

  // A port still seeing its done pulse must not be re-granted.
  assign elig = (rd | wr) & ~done_q;

  sdram_rr_pick u_pick (
    .eligible_i (elig),
    .last_i     (last_q),
    .gnt_o      (pick)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    crd_d   = crd_q;
    cwr_d   = cwr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    done_d  = 2'b00;
    unique case (state_q)
      ARB_IDLE: begin
        if (|elig) begin
          state_d = ARB_BUSY;
          gnt_d   = pick;
          last_d  = pick;
          cwr_d   = wr[pick];
          crd_d   = rd[pick] & ~wr[pick];
          addr_d  = pick ? p1_addr_i : p0_addr_i;
          wdat_d  = pick ? p1_data_i : p0_data_i;
        end
      end
      ARB_BUSY: begin
        if (ctrl_done_i) begin
          state_d       = ARB_IDLE;
          crd_d         = 1'b0;
          cwr_d         = 1'b0;
          done_d[gnt_q] = 1'b1;
          if (gnt_q) rd1_d = ctrl_data_i;
          else       rd0_d = ctrl_data_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      crd_q   <= 1'b0;
      cwr_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      crd_q   <= crd_d;
      cwr_q   <= cwr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      done_q  <= done_d;
    end
  end

  assign ctrl_rd_o   = crd_q;
  assign ctrl_wr_o   = cwr_q;
  assign ctrl_addr_o = addr_q;
  assign ctrl_data_o = wdat_q;
  assign p0_data_o   = rd0_q;
  assign p1_data_o   = rd1_q;
  assign p0_done_o   = done_q[0];
  assign p1_done_o   = done_q[1];

`ifdef SDARB_STATS_EN
  logic [1:0][CNT_W-1:0] cnt_q;

  // Counts step on the same edge that raises done_o, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (done_d[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign p0_count_o = cnt_q[0];
  assign p1_count_o = cnt_q[1];
`endif

endmodule
